// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide unit for the EX stage, one step per cycle
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   flush           synchronous abort, wins over start
//   start, op       M-extension request and funct3, sampled only in IDLE
//   rs1Data_ex      operand a
//   rs2Data_ex      operand b
//   rdAddr_ex       destination register
//   stall           holds PC, IF/ID and ID/EX
//   busy            FSM not in IDLE
//   done            one-cycle pulse with result and rdAddr_md valid
//   result          registered result
//   rdAddr_md       registered destination address
module ex_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1Data_ex,
    input  logic [XLEN-1:0] rs2Data_ex,
    input  logic [4:0]      rdAddr_ex,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rdAddr_md
);
    localparam int CW = $clog2(XLEN);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t            state;
    logic [CW-1:0]     count;
    logic [2:0]        op_q;
    logic [4:0]        rd_q;
    logic [XLEN-1:0]   hi, lo, mb;
    logic              sa, neg;
    logic              is_div, a_signed, b_signed, sa_in, sb_in, div_ge;
    logic [XLEN:0]     mul_sum, div_r, div_d;
    logic [XLEN-1:0]   hi_nx, lo_nx, q_fix, r_fix, res_nx;
    logic [2*XLEN-1:0] prod;
    // hi:lo is shared: {partial product, multiplier} for MUL*, {remainder, dividend/quotient} for DIV/REM
    always_comb begin
        a_signed = op inside {3'd1, 3'd2, 3'd4, 3'd6};
        b_signed = op inside {3'd1, 3'd4, 3'd6};
        sa_in    = a_signed & rs1Data_ex[XLEN-1];
        sb_in    = b_signed & rs2Data_ex[XLEN-1];
        is_div   = op_q[2];
        mul_sum  = {1'b0, hi} + {1'b0, (lo[0] ? mb : {XLEN{1'b0}})};
        div_r    = {hi, lo[XLEN-1]};
        div_d    = div_r - {1'b0, mb};
        div_ge   = ~div_d[XLEN];
        hi_nx    = is_div ? (div_ge ? div_d[XLEN-1:0] : div_r[XLEN-1:0]) : mul_sum[XLEN:1];
        lo_nx    = is_div ? {lo[XLEN-2:0], div_ge} : {mul_sum[0], lo[XLEN-1:1]};
        prod     = neg ? -{hi_nx, lo_nx} : {hi_nx, lo_nx};
        // with a zero divisor the remainder naturally ends as |a|; only the quotient needs forcing
        q_fix    = ~|mb ? {XLEN{1'b1}} : (neg ? -lo_nx : lo_nx);
        r_fix    = sa ? -hi_nx : hi_nx;
        res_nx   = is_div ? (op_q[1] ? r_fix : q_fix)
                          : (op_q[1:0] == 2'd0 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            op_q      <= '0;
            rd_q      <= '0;
            hi        <= '0;
            lo        <= '0;
            mb        <= '0;
            sa        <= 1'b0;
            neg       <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            rdAddr_md <= '0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state <= IDLE;
            end else if (state == IDLE) begin
                if (start) begin
                    state <= CALC;
                    op_q  <= op;
                    rd_q  <= rdAddr_ex;
                    count <= '0;
                    hi    <= '0;
                    lo    <= sa_in ? -rs1Data_ex : rs1Data_ex;
                    mb    <= sb_in ? -rs2Data_ex : rs2Data_ex;
                    sa    <= sa_in;
                    neg   <= sa_in ^ sb_in;
                end
            end else if (state == CALC) begin
                hi    <= hi_nx;
                lo    <= lo_nx;
                count <= count + 1'b1;
                if (count == CW'(XLEN-1)) begin
                    state     <= DONE;
                    done      <= 1'b1;
                    result    <= res_nx;
                    rdAddr_md <= rd_q;
                end
            end else begin
                state <= IDLE;
            end
        end
    end
    assign busy  = state != IDLE;
    assign stall = (state == IDLE && start) || state == CALC;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: scoreboard bench for the iterative multiply/divide unit
module tb_ex_muldiv_unit;
    logic        clk = 0, rst = 1, flush = 0, start = 0;
    logic [2:0]  op = 0;
    logic [31:0] rs1 = 0, rs2 = 0;
    logic [4:0]  rd = 0;
    logic        stall, busy, done;
    logic [31:0] result;
    logic [4:0]  rd_md;
    int          cyc = 0, n_chk = 0, n_err = 0, last_done = 0, prev_done = 0;
    logic [31:0] last_exp = 0;
    typedef struct { logic [31:0] res; logic [4:0] rd; } exp_t;
    exp_t        sb_q[$];
    exp_t        e_mon;

    ex_muldiv_unit dut (
        .clk(clk), .rst(rst), .flush(flush), .start(start), .op(op),
        .rs1Data_ex(rs1), .rs2Data_ex(rs2), .rdAddr_ex(rd),
        .stall(stall), .busy(busy), .done(done), .result(result), .rdAddr_md(rd_md)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      p;
        logic [63:0] u;
        int          sa, sb;
        logic        ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (o)
            3'd0: begin p = longint'(sa) * longint'(sb); return p[31:0]; end
            3'd1: begin p = longint'(sa) * longint'(sb); return p[63:32]; end
            3'd2: begin p = longint'(sa) * longint'({32'd0, b}); return p[63:32]; end
            3'd3: begin u = {32'd0, a} * {32'd0, b}; return u[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                return sa / sb;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                return sa % sb;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    always @(negedge clk) if (done) begin
        prev_done = last_done;
        last_done = cyc;
        if (sb_q.size() == 0) check("unexpected_done", done, 0);
        else begin
            e_mon = sb_q.pop_front();
            last_exp = e_mon.res;
            check("result", result, e_mon.res);
            check("rd_md", rd_md, e_mon.rd);
        end
    end

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] r, input bit hold = 0);
        int   t0, st;
        exp_t e;
        @(negedge clk);
        check("done_pulse", done, 0);
        op = o; rs1 = a; rs2 = b; rd = r; start = 1;
        e.res = model(o, a, b);
        e.rd = r;
        sb_q.push_back(e);
        t0 = cyc;
        st = 0;
        do begin
            #1 if (stall) st++;
            @(negedge clk);
            start = hold;
            op = 3'($urandom); rs1 = $urandom; rs2 = $urandom; rd = 5'($urandom);
        end while (!done && cyc - t0 < 40);
        start = 0;
        check("latency", cyc - t0, 33);
        check("stall_cycles", st, 33);
        #1 check("stall_in_done", stall, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_rd_md", rd_md, 0);
        check("rst_stall", stall, 0);
        rst = 0;
        // multiply
        run_op(3'd0, 32'd7, 32'd6, 5'd5);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd3, 1);
        // divide
        run_op(3'd4, -32'sd7, 32'd2, 5'd4);
        run_op(3'd6, -32'sd7, 32'd2, 5'd6);
        run_op(3'd5, 32'd100, 32'd7, 5'd7);
        run_op(3'd7, 32'd100, 32'd7, 5'd8, 1);
        // corner cases
        run_op(3'd4, 32'd5, 32'd0, 5'd9);
        run_op(3'd7, 32'd5, 32'd0, 5'd10);
        run_op(3'd6, -32'sd9, 32'd0, 5'd11);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13);
        // back-to-back
        run_op(3'd0, 32'd12345, 32'd678, 5'd14);
        run_op(3'd5, 32'hDEAD_BEEF, 32'd1000, 5'd15);
        check("b2b_gap", last_done - prev_done, 34);
        // flush mid-operation
        @(negedge clk);
        op = 3'd4; rs1 = -32'sd100; rs2 = 32'd7; rd = 5'd20; start = 1;
        @(negedge clk);
        start = 0;
        repeat (9) @(negedge clk);
        flush = 1;
        @(negedge clk);
        flush = 0;
        check("flush_busy", busy, 0);
        check("flush_stall", stall, 0);
        check("flush_result", result, last_exp);
        // flush beats start in IDLE
        start = 1; flush = 1;
        @(negedge clk);
        start = 0; flush = 0;
        check("flush_vs_start_busy", busy, 0);
        repeat (40) @(negedge clk);
        check("flush_result_hold", result, last_exp);
        run_op(3'd6, 32'd1000, -32'sd33, 5'd21);
        // reset mid-operation
        @(negedge clk);
        op = 3'd0; rs1 = 32'd99; rs2 = 32'd77; rd = 5'd22; start = 1;
        @(negedge clk);
        start = 0;
        repeat (14) @(negedge clk);
        rst = 1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_stall", stall, 0);
        check("arst_done", done, 0);
        check("arst_result", result, 0);
        check("arst_rd_md", rd_md, 0);
        @(negedge clk);
        rst = 0;
        repeat (40) @(negedge clk);
        check("arst_no_done_result", result, 0);
        // random operations
        for (int i = 0; i < 12; i++)
            run_op(3'($urandom), $urandom, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom, 5'($urandom));
        @(negedge clk);
        check("sb_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
